// File: rtl/quadrature_decoder_multi_if.sv
// quadrature_decoder_multi_if: encoder pins, control strobes and count readout bundle
interface quadrature_decoder_multi_if #(
  parameter int N_CH = 1,
  parameter int CNT_W = 32
);
  logic [N_CH-1:0] input_A;
  logic [N_CH-1:0] input_B;
  logic [N_CH-1:0] clear;
  logic err_clr;
  logic [N_CH*CNT_W-1:0] count;
  logic [N_CH-1:0] direction;
  logic [N_CH-1:0] err;
  modport master (
    output input_A, input_B, clear, err_clr,
    input count, direction, err
  );
  modport slave (
    input input_A, input_B, clear, err_clr,
    output count, direction, err
  );
endinterface

// File: rtl/quadrature_decoder_multi.sv
// quadrature_decoder_multi: N-channel synchronised, glitch-filtered x4 quadrature decoder
module quadrature_decoder_multi #(
  parameter int N_CH = 1,
  parameter int CNT_W = 32,
  parameter int FILT_LEN = 2,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic reset,
  quadrature_decoder_multi_if.slave bus
);
  localparam int SW = $clog2(FILT_LEN + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  logic [N_CH-1:0] a_m, a_s, b_m, b_s;
  logic [1:0] s [N_CH];
  logic [1:0] s_q [N_CH];
  logic [1:0] f [N_CH];
  logic [1:0] f_d [N_CH];
  logic [1:0] diff [N_CH];
  logic [SW-1:0] stab [N_CH];
  logic [SW-1:0] run [N_CH];
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] cnt_nx [N_CH];
  logic [N_CH-1:0] step, up, bad, dir, er;
  logic [N_CH*CNT_W-1:0] cnt_flat;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_m <= '0;
      a_s <= '0;
      b_m <= '0;
      b_s <= '0;
    end else begin
      a_m <= bus.input_A;
      a_s <= a_m;
      b_m <= bus.input_B;
      b_s <= b_m;
    end
  end
  always_comb begin
    step = '0;
    up = '0;
    bad = '0;
    for (int c = 0; c < N_CH; c++) begin
      s[c] = {a_s[c], b_s[c]};
      run[c] = (s[c] != s_q[c]) ? SW'(1) : stab[c] + SW'(1);
      diff[c] = {f[c][0], ^f[c]} - {f_d[c][0], ^f_d[c]};
      step[c] = diff[c][0];
      up[c] = diff[c] == 2'd1;
      bad[c] = diff[c] == 2'd2;
      cnt_nx[c] = bus.clear[c] ? '0 :
                  !step[c] ? cnt[c] :
                  up[c] ? ((SATURATE != 0 && cnt[c] == CNT_MAX) ? cnt[c] : cnt[c] + CNT_W'(1)) :
                  ((SATURATE != 0 && cnt[c] == CNT_MIN) ? cnt[c] : cnt[c] - CNT_W'(1));
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset) begin
        s_q[c] <= '0;
        stab[c] <= '0;
        f[c] <= '0;
        f_d[c] <= '0;
        cnt[c] <= '0;
        dir[c] <= 1'b0;
        er[c] <= 1'b0;
      end else begin
        s_q[c] <= s[c];
        stab[c] <= (run[c] >= SW'(FILT_LEN)) ? SW'(FILT_LEN) : run[c];
        if (s[c] != f[c] && run[c] >= SW'(FILT_LEN)) f[c] <= s[c];
        f_d[c] <= f[c];
        cnt[c] <= cnt_nx[c];
        if (step[c]) dir[c] <= !up[c];
        er[c] <= bad[c] | (er[c] & !bus.err_clr);
      end
    end
  end
  always_comb begin
    cnt_flat = '0;
    for (int c = 0; c < N_CH; c++) cnt_flat[c*CNT_W +: CNT_W] = cnt[c];
  end
  assign bus.count = cnt_flat;
  assign bus.direction = dir;
  assign bus.err = er;
endmodule
